// File: rtl/vga_pkg.sv
// Shared types and reference constants for the VGA timing monitor.
package vga_pkg;

    localparam int unsigned REC_W    = 16;
    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_TOTAL  = 525;
    localparam int unsigned V_ACTIVE = 480;

    typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_e;

    typedef struct packed {
        logic [REC_W-1:0] h_total;
        logic [REC_W-1:0] h_active;
        logic [REC_W-1:0] v_total;
        logic [REC_W-1:0] v_active;
    } frame_rec_t;

endpackage

// File: rtl/vga_timing_monitor_sampler.sv
// Pixel-enable recovery and sync/blank edge strobes, one pixel of latency.
module vga_edge_sampler
    import vga_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic pixel_clk_i,
    input  logic hs_i,
    input  logic vs_i,
    input  logic blank_i,
    output logic pix_en_o,
    output logic blank_q_o,
    output logic h_fall_o,
    output logic v_fall_o,
    output logic a_rise_o
);

    logic pclk_q, pclk_d;
    logic hs_q, hs_d;
    logic vs_q, vs_d;
    logic blank_q, blank_d;
    logic pix_en;

    always_comb begin
        pclk_d    = pixel_clk_i;
        pix_en    = pixel_clk_i & ~pclk_q;
        hs_d      = pix_en ? hs_i    : hs_q;
        vs_d      = pix_en ? vs_i    : vs_q;
        blank_d   = pix_en ? blank_i : blank_q;
        pix_en_o  = pix_en;
        blank_q_o = blank_q;
        h_fall_o  = pix_en & hs_q & ~hs_i;
        v_fall_o  = pix_en & vs_q & ~vs_i;
        a_rise_o  = pix_en & ~blank_q & blank_i;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pclk_q  <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            pclk_q  <= pclk_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
        end
    end

endmodule

// File: rtl/vga_timing_monitor.sv
// Recovers pixel coordinates and line/frame geometry from VGA sync/blank
// and declares lock once consecutive frames agree.
module vga_timing_monitor
    import vga_pkg::*;
#(
    parameter int unsigned CW          = 11,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned VS_TIMEOUT  = 1_000_000
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          pixel_clk,
    input  logic          hs,
    input  logic          vs,
    input  logic          blank,
    output logic [9:0]    x,
    output logic [9:0]    y,
    output logic          active,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] v_total,
    output logic [CW-1:0] h_active,
    output logic [CW-1:0] v_active,
    output logic          frame_start,
    output logic          locked,
    output logic          err
);

    localparam int unsigned   TW    = $clog2(VS_TIMEOUT + 1);
    localparam logic [CW-1:0] CMAX  = {CW{1'b1}};
    localparam logic [TW-1:0] TMAX  = TW'(VS_TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(VS_TIMEOUT - 1);

    logic pix_en, blank_q, h_fall, v_fall, a_rise;

    vga_edge_sampler u_sampler (
        .Clk        (Clk),
        .Reset      (Reset),
        .pixel_clk_i(pixel_clk),
        .hs_i       (hs),
        .vs_i       (vs),
        .blank_i    (blank),
        .pix_en_o   (pix_en),
        .blank_q_o  (blank_q),
        .h_fall_o   (h_fall),
        .v_fall_o   (v_fall),
        .a_rise_o   (a_rise)
    );

    logic [CW-1:0] hcnt_q, hcnt_d, acnt_q, acnt_d, lcnt_q, lcnt_d, vacnt_q, vacnt_d;
    logic [CW-1:0] line_len_q, line_len_d, h_act_cur_q, h_act_cur_d;
    logic [CW-1:0] acnt_nx, lcnt_nx, vacnt_nx;
    logic          line_vis_q, line_vis_d, vis_frame_q, vis_frame_d, line_has_vis;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          sat_evt, tout_evt;
    frame_rec_t    rec_new;

    always_comb begin
        hcnt_d       = hcnt_q;
        acnt_d       = acnt_q;
        lcnt_d       = lcnt_q;
        vacnt_d      = vacnt_q;
        line_len_d   = line_len_q;
        h_act_cur_d  = h_act_cur_q;
        line_vis_d   = line_vis_q;
        vis_frame_d  = vis_frame_q;
        x_d          = x_q;
        y_d          = y_q;
        acnt_nx      = acnt_q;
        lcnt_nx      = lcnt_q;
        vacnt_nx     = vacnt_q;
        sat_evt      = 1'b0;
        line_has_vis = line_vis_q | blank;
        if (pix_en) begin
            if (blank && acnt_q != CMAX) acnt_nx = acnt_q + 1'b1;
            if (h_fall) begin
                line_len_d = (hcnt_q == CMAX) ? CMAX : hcnt_q + 1'b1;
                hcnt_d     = '0;
                acnt_d     = '0;
                line_vis_d = 1'b0;
                if (line_has_vis) h_act_cur_d = acnt_nx;
                if (lcnt_q != CMAX) lcnt_nx = lcnt_q + 1'b1;
                if (line_has_vis && vacnt_q != CMAX) vacnt_nx = vacnt_q + 1'b1;
            end else begin
                if (hcnt_q != CMAX) hcnt_d = hcnt_q + 1'b1;
                acnt_d     = acnt_nx;
                line_vis_d = line_has_vis;
            end
            // Flag only the transition into saturation, not every held cycle.
            sat_evt = (hcnt_d == CMAX && hcnt_q != CMAX) || (acnt_nx == CMAX && acnt_q != CMAX)
                   || (lcnt_nx == CMAX && lcnt_q != CMAX)
                   || (vacnt_nx == CMAX && vacnt_q != CMAX);
            lcnt_d  = v_fall ? '0 : lcnt_nx;
            vacnt_d = v_fall ? '0 : vacnt_nx;
            if (a_rise) begin
                x_d = '0;
            end else if (blank) begin
                x_d = x_q + 1'b1;
            end
            if (v_fall) begin
                y_d         = '0;
                vis_frame_d = 1'b0;
            end else if (a_rise && !line_vis_q) begin
                if (vis_frame_q) y_d = y_q + 1'b1;
                vis_frame_d = 1'b1;
            end
        end
        // Record reflects a line closed on this same pixel before the frame closes.
        rec_new = '{h_total:  REC_W'(line_len_d),
                    h_active: REC_W'(h_act_cur_d),
                    v_total:  REC_W'(lcnt_nx),
                    v_active: REC_W'(vacnt_nx)};
        tcnt_d   = tcnt_q;
        if (v_fall) begin
            tcnt_d = '0;
        end else if (tcnt_q != TMAX) begin
            tcnt_d = tcnt_q + 1'b1;
        end
        tout_evt = (tcnt_q == TLAST) && !v_fall;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hcnt_q      <= '0;
            acnt_q      <= '0;
            lcnt_q      <= '0;
            vacnt_q     <= '0;
            line_len_q  <= '0;
            h_act_cur_q <= '0;
            line_vis_q  <= 1'b0;
            vis_frame_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            tcnt_q      <= '0;
        end else begin
            hcnt_q      <= hcnt_d;
            acnt_q      <= acnt_d;
            lcnt_q      <= lcnt_d;
            vacnt_q     <= vacnt_d;
            line_len_q  <= line_len_d;
            h_act_cur_q <= h_act_cur_d;
            line_vis_q  <= line_vis_d;
            vis_frame_q <= vis_frame_d;
            x_q         <= x_d;
            y_q         <= y_d;
            tcnt_q      <= tcnt_d;
        end
    end

    state_e     state_q;
    logic [3:0] mcnt_q;
    frame_rec_t ref_q, pub_q;
    logic       locked_q, err_q, frame_start_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= SEARCH;
            mcnt_q        <= '0;
            ref_q         <= '0;
            pub_q         <= '0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            err_q         <= 1'b0;
            frame_start_q <= v_fall;
            if (sat_evt || (tout_evt && state_q != SEARCH)) begin
                err_q    <= 1'b1;
                locked_q <= 1'b0;
                state_q  <= SEARCH;
            end else begin
                unique case (state_q)
                    SEARCH: begin
                        if (v_fall) state_q <= MEASURE;
                    end
                    MEASURE: begin
                        if (v_fall) begin
                            ref_q  <= rec_new;
                            mcnt_q <= 4'd1;
                            if (LOCK_FRAMES <= 1) begin
                                pub_q    <= rec_new;
                                locked_q <= 1'b1;
                                state_q  <= LOCKED;
                            end else begin
                                state_q <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        if (v_fall) begin
                            if (rec_new == ref_q) begin
                                mcnt_q <= mcnt_q + 1'b1;
                                if (32'(mcnt_q) + 32'd1 >= LOCK_FRAMES) begin
                                    pub_q    <= rec_new;
                                    locked_q <= 1'b1;
                                    state_q  <= LOCKED;
                                end
                            end else begin
                                err_q  <= 1'b1;
                                ref_q  <= rec_new;
                                mcnt_q <= 4'd1;
                            end
                        end
                    end
                    LOCKED: begin
                        if ((h_fall && REC_W'(line_len_d) != pub_q.h_total)
                            || (v_fall && rec_new != pub_q)) begin
                            err_q    <= 1'b1;
                            locked_q <= 1'b0;
                            state_q  <= SEARCH;
                        end
                    end
                    default: state_q <= SEARCH;
                endcase
            end
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign active      = blank_q;
    assign h_total     = pub_q.h_total[CW-1:0];
    assign h_active    = pub_q.h_active[CW-1:0];
    assign v_total     = pub_q.v_total[CW-1:0];
    assign v_active    = pub_q.v_active[CW-1:0];
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign err         = err_q;

endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
- Receive-side companion to the VGA timing generator.
- Observes the generator's hs, vs, blank and pixel_clk outputs in the 50 MHz Clk domain.
- Recovers active-area pixel coordinates and measures line and frame geometry.
- Declares lock once the timing is stable. Used as a self-check and as a coordinate source for overlay and capture logic on the VGA output path.

Parameters:
- CW, 11, width of internal pixel/line counters; saturate at 2^CW-1.
- LOCK_FRAMES, 2, consecutive identical frames required to assert locked (1..15).
- VS_TIMEOUT, 1_000_000, Clk cycles without a vs falling edge before lock is dropped.

Ports:
- Clk  in  1  50 MHz system clock.
- Reset  in  1  asynchronous, active-high.
- pixel_clk  in  1  25 MHz pixel clock as a level, sampled in the Clk domain.
- hs  in  1  horizontal sync, active low.
- vs  in  1  vertical sync, active low.
- blank  in  1  display-enable, active low (1 = visible pixel).
- x  out  10  active-area column, 0..h_active-1.
- y  out  10  active-area row, 0..v_active-1.
- active  out  1  registered copy of blank at current pixel.
- h_total  out  CW  measured pixels per line.
- v_total  out  CW  measured lines per frame.
- h_active  out  CW  measured visible pixels per line.
- v_active  out  CW  measured visible lines per frame.
- frame_start  out  1  one-Clk pulse on vs falling edge.
- locked  out  1  timing stable.
- err  out  1  one-Clk pulse on geometry mismatch, timeout or counter saturation.

Behaviour:

Reset and sampling:
- Reset: all outputs 0; state SEARCH; counters, measurements and edge registers cleared.
- pix_en = pixel_clk & ~pixel_clk_q, where pixel_clk_q is pixel_clk registered on Clk. Exactly one pix_en per pixel.
- hs, vs and blank are registered only on pix_en cycles (hs_q, vs_q, blank_q). All detection uses these registered copies, so latency is one pixel.

Edge detection (pix_en cycles only):
- h_fall = hs_q & ~hs.
- v_fall = vs_q & ~vs.
- a_rise = ~blank_q & blank.

Counters (advance on pix_en only):
- hcnt: +1 per pixel; cleared on h_fall, which latches hcnt+1 into line_len.
- acnt: +1 per pixel with blank=1; latched into h_act_cur and cleared on h_fall.
- lcnt: +1 per h_fall.
- vacnt: +1 per h_fall of a line that contained any blank=1 pixel.
- On v_fall: lcnt and vacnt are latched into the frame record and cleared.
- Any counter reaching 2^CW-1 holds that value, pulses err and forces SEARCH.

Coordinates:
- x clears on a_rise; otherwise increments on each pix_en with blank=1.
- y clears on v_fall; increments on the first a_rise of each line after the first visible line of the frame.
- x and y hold their values during blanking.
- active = blank_q.

State machine:
- SEARCH: wait for v_fall → MEASURE.
- MEASURE: capture one full frame record (line_len, h_act_cur of the last visible line, lcnt, vacnt) into the reference set. At the next v_fall → VERIFY with match count = 1.
- VERIFY: at each v_fall, compare the new frame record to the reference.
  - Equal: match count +1; when it reaches LOCK_FRAMES → LOCKED and publish h_total, v_total, h_active, v_active.
  - Unequal: err pulse, reload the reference with the new record, match count = 1, stay in VERIFY.
- LOCKED: locked = 1.
  - Every h_fall must give line_len == h_total; any mismatch → err, locked = 0, SEARCH.
  - Every v_fall frame record must equal the published set; any mismatch → err, locked = 0, SEARCH.

Timeout:
- A free-running Clk counter clears on each v_fall.
- Reaching VS_TIMEOUT in any state other than SEARCH → err, locked = 0, SEARCH.

Ordering and mid-operation rules:
- Simultaneous h_fall and v_fall on one pix_en: the line is closed first (lcnt includes it), then the frame is latched.
- Published measurement outputs hold their last values after lock loss until the next publish.
- frame_start pulses on every v_fall regardless of state.
- Reset mid-frame: immediate return to the reset state; re-lock needs LOCK_FRAMES+1 vs falling edges.

Decomposition:
- Package vga_pkg holds:
  - typedef enum of the states {SEARCH, MEASURE, VERIFY, LOCKED};
  - typedef struct frame_rec_t {h_total, h_active, v_total, v_active};
  - 640x480 constants H_TOTAL=800, H_ACTIVE=640, V_TOTAL=525, V_ACTIVE=480.
- One sub-module: vga_edge_sampler. It produces pix_en, the registered hs/vs/blank and the h_fall, v_fall and a_rise strobes.

Test Plan:
- Drive the standard 640x480 generator waveform (800×525, hs low at pixels 656-751, vs low on lines 490-491) → h_total=800, v_total=525, h_active=640, v_active=480; locked rises at the 3rd vs falling edge; err never pulses.
- While locked, check coordinates → first visible pixel after vs gives x=0, y=0; last visible pixel gives x=639, y=479; x and y hold during blanking.
- While locked, lengthen one line to 801 pixels → err pulses once at that hs falling edge, locked=0; relocks 3 frames later.
- Hold vs high for more than VS_TIMEOUT Clk cycles → err pulse, locked=0; h_total keeps 800.
- Assert Reset mid-frame while locked → all outputs 0 on the same cycle; after release, locked returns only after the 3rd vs falling edge.
- Hold hs high permanently (no hs falling edges) → hcnt saturates at 2047, err pulses, state returns to SEARCH.
